accumulator_source: RTL and testbench
=====================================

# accumulator_source

Initiator-side companion to the accumulator core: it generates a programmed burst of operand words on a valid/ready transmit channel, then collects the accumulated result on a valid/ready receive channel and checks it against its own model of the running sum. It sits at the accumulator's input/output pair and serves as on-chip traffic source and self-checker for bring-up and BIST.

## Interface
- DATA_WIDTH, 32, width of operand, result and model sum
- COUNT_WIDTH, 16, width of burst length
- TIMEOUT_CYCLES, 1024, result watchdog limit; used only with ACCUMULATOR_SOURCE_TIMEOUT_EN
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle burst request; honoured only in IDLE
- cfg_base  in  DATA_WIDTH  first operand
- cfg_step  in  DATA_WIDTH  operand increment
- cfg_count  in  COUNT_WIDTH  number of operands; 0 allowed
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at burst completion
- pass  out  1  result matched model; valid from done, held until next done
- timeout  out  1  last burst ended by watchdog; held until next done
- result  out  DATA_WIDTH  last received result; held until next done
- tx_valid  out  1  operand valid
- tx_data  out  DATA_WIDTH  operand
- tx_ready  in  1  accumulator accepts operand
- rx_valid  in  1  result valid
- rx_data  in  DATA_WIDTH  accumulated result
- rx_ready  out  1  source accepts result

## Operation
- States: IDLE, SEND, COLLECT, REPORT.
- IDLE + start: latch cfg_base/step/count. count≠0 → SEND with tx_data=cfg_base; count=0 → COLLECT.
- SEND: tx_valid=1. On tx_valid&tx_ready: model += tx_data, remaining -= 1, tx_data += step. Last word accepted → COLLECT.
- tx_data and tx_valid are held stable while tx_ready is low; tx_valid never drops before acceptance.
- Operand k = base + k·step, modulo 2^DATA_WIDTH. Model sum wraps modulo 2^DATA_WIDTH.
- Model sum persists across bursts (the accumulator does not clear between bursts); cleared only by rst_n.
- COLLECT: rx_ready=1. On rx_valid&rx_ready: result←rx_data, pass←(rx_data==model), timeout←0 → REPORT.
- REPORT: done=1 for one cycle → IDLE.
- start outside IDLE is ignored; cfg inputs are sampled only at the accepted start.
- rx_valid outside COLLECT is ignored (rx_ready=0).

## Timing
- Reset values: busy=0, done=0, pass=0, timeout=0, result=0, tx_valid=0, tx_data=0, rx_ready=0, model=0, state IDLE.
- All outputs registered.
- tx_valid rises the cycle after accepted start; with tx_ready held high, N operands take N consecutive cycles.
- rx_ready rises the cycle after the last operand handshake (or after start when count=0).
- done pulses the cycle after the rx handshake; busy falls in the same cycle as the done pulse; a new start is accepted in the following cycle.
- Minimum burst with count=N, no stalls: start to done = N+2 cycles plus the responder's rx_valid latency.
- Reset asserted mid-burst: immediate return to reset values; partial burst discarded; no done.

## Configuration
- ACCUMULATOR_SOURCE_TIMEOUT_EN defined: a counter runs in COLLECT. If TIMEOUT_CYCLES elapse without an rx handshake: timeout←1, pass←0, result unchanged → REPORT (done pulses). The model sum is not rolled back.
- Not defined: no watchdog; COLLECT waits indefinitely; timeout output tied to 0.

## Test plan
- base=1, step=1, count=4, tx_ready=1, responder returns 10 → tx_data 1,2,3,4 on consecutive cycles, done, pass=1, result=10.
- Same burst after reset, with tx_ready toggling 1,0,0,1,… → each word held during stall, same sequence, pass=1.
- Following burst base=5, step=0, count=2, responder returns 20 → pass=1 (model 10+10).
- Responder returns 11 instead of 10 → pass=0, result=11; start pulsed while busy has no effect.
- count=0 → no tx_valid; rx_ready next cycle; responder returns current model → pass=1.
- Macro defined, TIMEOUT_CYCLES=8, rx_valid never asserted → done 8 cycles into COLLECT, timeout=1, pass=0; reset mid-SEND → all outputs at reset values.

Source files
------------

// File: rtl/accumulator_source.sv
// Burst operand source and result checker for the accumulator core.
// Optional result watchdog is enabled by defining ACCUMULATOR_SOURCE_TIMEOUT_EN.
module accumulator_source #(
  parameter int DATA_WIDTH     = 32,
  parameter int COUNT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  cfg_base,
  input  logic [DATA_WIDTH-1:0]  cfg_step,
  input  logic [COUNT_WIDTH-1:0] cfg_count,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   tx_valid,
  output logic [DATA_WIDTH-1:0]  tx_data,
  input  logic                   tx_ready,
  input  logic                   rx_valid,
  input  logic [DATA_WIDTH-1:0]  rx_data,
  output logic                   rx_ready,
  output logic [1:0]             dbg_state
);

  // Valid/ready: a word transfers on any rising edge where valid and ready are
  // both high; the sender holds valid high and data stable until that edge.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    COLLECT = 2'd2,
    REPORT  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                   rx_ready_q, rx_ready_d;
  logic [DATA_WIDTH-1:0]  step_q, step_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0]  model_q, model_d;

`ifdef ACCUMULATOR_SOURCE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic          timeout_q, timeout_d;
  logic [TW-1:0] timer_q, timer_d;
`endif

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    result_d    = result_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    rx_ready_d  = rx_ready_q;
    step_d      = step_q;
    remaining_d = remaining_q;
    model_d     = model_q;
`ifdef ACCUMULATOR_SOURCE_TIMEOUT_EN
    timeout_d   = timeout_q;
    timer_d     = timer_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          step_d = cfg_step;
`ifdef ACCUMULATOR_SOURCE_TIMEOUT_EN
          timer_d = '0;
`endif
          if (cfg_count != '0) begin
            state_d     = SEND;
            tx_valid_d  = 1'b1;
            tx_data_d   = cfg_base;
            remaining_d = cfg_count;
          end else begin
            state_d    = COLLECT;
            rx_ready_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (tx_valid_q && tx_ready) begin
          model_d     = model_q + tx_data_q;
          tx_data_d   = tx_data_q + step_q;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == COUNT_WIDTH'(1)) begin
            state_d    = COLLECT;
            tx_valid_d = 1'b0;
            rx_ready_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (rx_valid && rx_ready_q) begin
          state_d    = REPORT;
          result_d   = rx_data;
          pass_d     = (rx_data == model_q);
          rx_ready_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
`ifdef ACCUMULATOR_SOURCE_TIMEOUT_EN
          timeout_d  = 1'b0;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // Watchdog expiry keeps the last result and the model as they are.
          state_d    = REPORT;
          timeout_d  = 1'b1;
          pass_d     = 1'b0;
          rx_ready_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          timer_d    = timer_q + 1'b1;
`endif
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      result_q    <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      rx_ready_q  <= 1'b0;
      step_q      <= '0;
      remaining_q <= '0;
      model_q     <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      result_q    <= result_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      rx_ready_q  <= rx_ready_d;
      step_q      <= step_d;
      remaining_q <= remaining_d;
      model_q     <= model_d;
    end
  end

`ifdef ACCUMULATOR_SOURCE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      timeout_q <= timeout_d;
      timer_q   <= timer_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign result    = result_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign rx_ready  = rx_ready_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_accumulator_source.sv
// Directed bench for accumulator_source; the watchdog scenario runs only
// when ACCUMULATOR_SOURCE_TIMEOUT_EN is defined.
module tb_accumulator_source;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfg_base = '0;
  logic [31:0] cfg_step = '0;
  logic [15:0] cfg_count = '0;
  logic        busy, done, pass, timeout;
  logic [31:0] result;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_ready;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  // Observations recorded by the driver, compared by each scenario task
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          hold_err, done_cyc, rx_ready_cyc, first_tx_cyc, tx_seen;
  logic        busy_at_done;

  accumulator_source #(
    .DATA_WIDTH(32), .COUNT_WIDTH(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_base(cfg_base), .cfg_step(cfg_step), .cfg_count(cfg_count),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .result(result),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Runs one burst from an IDLE phase (1 time unit after a rising edge).
  // Cycle numbers count edges after the start edge; the loop is bounded.
  task automatic do_burst(input logic [31:0] base, input logic [31:0] step,
                          input logic [15:0] count, input logic [31:0] resp,
                          input bit stall, input bit respond, input bit poke);
    int idx;
    logic pv, pr;
    logic [31:0] pd;
    got_q.delete();
    hold_err = 0; done_cyc = -1; rx_ready_cyc = -1; first_tx_cyc = -1; tx_seen = 0;
    busy_at_done = 1'b1;
    cfg_base = base; cfg_step = step; cfg_count = count; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_base = 32'hDEAD_BEEF; cfg_step = 32'd7; cfg_count = 16'd9;
    pv = 1'b0; pr = 1'b0; pd = '0; idx = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      start = poke && (cyc == 2);
      if (pv && !pr && !tx_valid) hold_err++;
      if (tx_valid) begin
        tx_ready = stall ? (idx % 3 == 0) : 1'b1;
        if (pv && !pr && tx_data !== pd) hold_err++;
        if (first_tx_cyc < 0) first_tx_cyc = cyc;
        tx_seen++; idx++;
        if (tx_ready) got_q.push_back(tx_data);
      end else begin
        tx_ready = !stall;
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data;
      if (rx_ready && rx_ready_cyc < 0) rx_ready_cyc = cyc;
      rx_valid = respond && rx_ready;
      rx_data = resp;
      if (done) begin
        done_cyc = cyc; busy_at_done = busy;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b exp=0", pass); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== 32'd0) begin errors++; $display("FAIL reset_tx_data got=%h exp=0", tx_data); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_basic();
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    do_burst(32'd1, 32'd1, 16'd4, 32'd10, 1'b0, 1'b1, 1'b0);
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL basic_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (first_tx_cyc !== 1) begin errors++; $display("FAIL basic_tx_rise got=%0d exp=1", first_tx_cyc); end
    checks++; if (rx_ready_cyc !== 5) begin errors++; $display("FAIL basic_rx_ready got=%0d exp=5", rx_ready_cyc); end
    checks++; if (done_cyc !== 6) begin errors++; $display("FAIL basic_done_cyc got=%0d exp=6", done_cyc); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%b exp=0", busy_at_done); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL basic_pass got=%b exp=1", pass); end
    checks++; if (result !== 32'd10) begin errors++; $display("FAIL basic_result got=%h exp=a", result); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout got=%b exp=0", timeout); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL basic_pass_held got=%b exp=1", pass); end
  endtask

  task automatic test_stall();
    apply_reset();
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    do_burst(32'd1, 32'd1, 16'd4, 32'd10, 1'b1, 1'b1, 1'b0);
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL stall_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (hold_err !== 0) begin errors++; $display("FAIL stall_hold got=%0d exp=0", hold_err); end
    checks++; if (tx_seen !== 10) begin errors++; $display("FAIL stall_valid_cycles got=%0d exp=10", tx_seen); end
    checks++; if (done_cyc !== 12) begin errors++; $display("FAIL stall_done_cyc got=%0d exp=12", done_cyc); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL stall_pass got=%b exp=1", pass); end
    @(posedge clk); #1;
  endtask

  task automatic test_persist();
    exp_q = '{32'd5, 32'd5};
    do_burst(32'd5, 32'd0, 16'd2, 32'd20, 1'b0, 1'b1, 1'b0);
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL persist_count got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL persist_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL persist_pass got=%b exp=1", pass); end
    checks++; if (result !== 32'd20) begin errors++; $display("FAIL persist_result got=%h exp=14", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_mismatch();
    apply_reset();
    do_burst(32'd1, 32'd1, 16'd4, 32'd11, 1'b0, 1'b1, 1'b1);
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL mismatch_count got=%0d exp=4", got_q.size()); end
    checks++; if (got_q.size() == 4 && got_q[3] !== 32'd4) begin errors++; $display("FAIL mismatch_last_word got=%h exp=4", got_q[3]); end
    checks++; if (done_cyc !== 6) begin errors++; $display("FAIL mismatch_done_cyc got=%0d exp=6", done_cyc); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL mismatch_pass got=%b exp=0", pass); end
    checks++; if (result !== 32'd11) begin errors++; $display("FAIL mismatch_result got=%h exp=b", result); end
    @(posedge clk); #1;
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL mismatch_idle got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_zero_count();
    do_burst(32'd77, 32'd3, 16'd0, 32'd10, 1'b0, 1'b1, 1'b0);
    checks++; if (tx_seen !== 0) begin errors++; $display("FAIL zero_tx_valid got=%0d exp=0", tx_seen); end
    checks++; if (rx_ready_cyc !== 1) begin errors++; $display("FAIL zero_rx_ready got=%0d exp=1", rx_ready_cyc); end
    checks++; if (done_cyc !== 2) begin errors++; $display("FAIL zero_done_cyc got=%0d exp=2", done_cyc); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL zero_pass got=%b exp=1", pass); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    exp_q = '{32'd2, 32'd5, 32'd8};
    do_burst(32'd2, 32'd3, 16'd3, 32'd25, 1'b0, 1'b1, 1'b0);
    checks++; if (first_tx_cyc !== 1) begin errors++; $display("FAIL b2b_tx_rise got=%0d exp=1", first_tx_cyc); end
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL b2b_pass got=%b exp=1", pass); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    exp_q = '{32'hFFFF_FFFF, 32'h0000_0000};
    do_burst(32'hFFFF_FFFF, 32'd1, 16'd2, 32'd24, 1'b0, 1'b1, 1'b0);
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL wrap_count got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL wrap_pass got=%b exp=1", pass); end
    checks++; if (result !== 32'd24) begin errors++; $display("FAIL wrap_result got=%h exp=18", result); end
    @(posedge clk); #1;
  endtask

`ifdef ACCUMULATOR_SOURCE_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    do_burst(32'd9, 32'd0, 16'd1, 32'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (rx_ready_cyc !== 2) begin errors++; $display("FAIL timeout_rx_ready got=%0d exp=2", rx_ready_cyc); end
    checks++; if (done_cyc !== 10) begin errors++; $display("FAIL timeout_done_cyc got=%0d exp=10", done_cyc); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag got=%b exp=1", timeout); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL timeout_pass got=%b exp=0", pass); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL timeout_result got=%h exp=0", result); end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_reset_mid_send();
    cfg_base = 32'd3; cfg_step = 32'd1; cfg_count = 16'd4; start = 1'b1; tx_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL midrst_sending got=%b exp=1", tx_valid); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== 32'd0) begin errors++; $display("FAIL midrst_tx_data got=%h exp=0", tx_data); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL midrst_timeout got=%b exp=0", timeout); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL midrst_state got=%0d exp=0", dbg_state); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_no_done got=%b exp=0", done); end
    // Model must be zero again: an empty burst answered with 0 has to pass
    do_burst(32'd0, 32'd0, 16'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL midrst_model_clear got=%b exp=1", pass); end
    checks++; if (done_cyc !== 2) begin errors++; $display("FAIL midrst_done_cyc got=%0d exp=2", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_persist();
    test_mismatch();
    test_zero_count();
    test_back_to_back();
    test_wrap();
`ifdef ACCUMULATOR_SOURCE_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
